// File: rtl/control_mosaicos_pkg.sv
// Shared constants, code values and FSM encoding for the tile-text sequencer.
package mosaicos_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CODE_W = 2;
  localparam int CELDAS = COLS * ROWS;
  localparam int DIR_W  = $clog2(CELDAS);

  localparam logic [CODE_W-1:0] COD_BLANCO = 2'b00;
  localparam logic [CODE_W-1:0] COD_D      = 2'b01;
  localparam logic [CODE_W-1:0] COD_J      = 2'b10;

  // Sized copies so range checks compare like-width operands.
  localparam logic [6:0]       COLS_L  = 7'(COLS);
  localparam logic [4:0]       ROWS_L  = 5'(ROWS);
  localparam logic [DIR_W-1:0] ULTIMA  = DIR_W'(CELDAS - 1);

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    ESCRIBE  = 2'd1,
    ESPERA   = 2'd2,
    BORRANDO = 2'd3
  } estado_t;

  function automatic logic [DIR_W-1:0] indice(input logic [4:0] fila, input logic [6:0] col);
    return DIR_W'(fila) * DIR_W'(COLS) + DIR_W'(col);
  endfunction

endpackage

// File: rtl/control_mosaicos_if.sv
// Bundle of sync-counter inputs, writer handshake, clear control and ROM-side outputs.
// Handshake: wr_req is held with stable wr_col/wr_fila/wr_codigo until a one-cycle
// wr_ack is seen; wr_err only ever pulses in the same cycle as wr_ack.
interface control_mosaicos_if;
  import mosaicos_pkg::*;

  logic [9:0]        Qh;
  logic [9:0]        Qv;
  logic              video_on;
  logic              wr_req;
  logic [6:0]        wr_col;
  logic [4:0]        wr_fila;
  logic [CODE_W-1:0] wr_codigo;
  logic              wr_ack;
  logic              wr_err;
  logic              borrar;
  logic              ocupado;
  logic [5:0]        rom_dir;
  logic [2:0]        selec_px;
  logic              pix_valido;
  estado_t           estado;

  modport master (
    output Qh, Qv, video_on, wr_req, wr_col, wr_fila, wr_codigo, borrar,
    input  wr_ack, wr_err, ocupado, rom_dir, selec_px, pix_valido, estado
  );

  modport slave (
    input  Qh, Qv, video_on, wr_req, wr_col, wr_fila, wr_codigo, borrar,
    output wr_ack, wr_err, ocupado, rom_dir, selec_px, pix_valido, estado
  );
endinterface

// File: rtl/control_mosaicos_mapa.sv
// Tile map RAM: one synchronous read port, one write port, index = fila*COLS+col.
module mapa_mosaicos
  import mosaicos_pkg::*;
(
  input  logic              reloj,
  input  logic              resetM,
  input  logic              rd_en,
  input  logic [DIR_W-1:0]  rd_dir,
  output logic [CODE_W-1:0] rd_dato,
  input  logic              we,
  input  logic [DIR_W-1:0]  wr_dir,
  input  logic [CODE_W-1:0] wr_dato
);

  logic [CODE_W-1:0] mem [CELDAS];

  always_ff @(posedge reloj) begin
    if (we) mem[wr_dir] <= wr_dato;
  end

  // Only the output register is reset; cell contents survive resetM.
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) rd_dato <= COD_BLANCO;
    else        rd_dato <= rd_en ? mem[rd_dir] : COD_BLANCO;
  end

endmodule

// File: rtl/control_mosaicos.sv
// Tile-text sequencer: display read pipeline toward the glyph ROM plus the map
// write/clear arbiter FSM sharing the single map write port.
module control_mosaicos
  import mosaicos_pkg::*;
(
  input  logic reloj,
  input  logic resetM,
  control_mosaicos_if.slave bus
);

  logic [9:0]        qh_c0, qv_c0;
  logic              vo_c0;
  logic [3:0]        qv_c1;
  logic [2:0]        sel_c1;
  logic              vo_c1;
  logic [2:0]        selec_px;
  logic              pix_valido;
  logic              rd_en;
  logic [DIR_W-1:0]  rd_dir;
  logic [CODE_W-1:0] codigo;

  estado_t           estado;
  logic [DIR_W-1:0]  cnt;
  logic              wr_ack, wr_err, ocupado;
  logic              en_rango;
  logic              we;
  logic [DIR_W-1:0]  wr_dir;
  logic [CODE_W-1:0] wr_dato;

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      qh_c0      <= '0;
      qv_c0      <= '0;
      vo_c0      <= 1'b0;
      qv_c1      <= '0;
      sel_c1     <= '0;
      vo_c1      <= 1'b0;
      selec_px   <= '0;
      pix_valido <= 1'b0;
    end else begin
      qh_c0      <= bus.Qh;
      qv_c0      <= bus.Qv;
      vo_c0      <= bus.video_on;
      qv_c1      <= qv_c0[3:0];
      sel_c1     <= qh_c0[2:0];
      vo_c1      <= vo_c0;
      selec_px   <= sel_c1;
      pix_valido <= vo_c1;
    end
  end

  // Qv[9] set means the row index wrapped; treat it as off-map.
  assign rd_en  = !qv_c0[9] && (qv_c0[8:4] < ROWS_L) && (qh_c0[9:3] < COLS_L);
  assign rd_dir = indice(qv_c0[8:4], qh_c0[9:3]);

  mapa_mosaicos u_mapa (
    .reloj   (reloj),
    .resetM  (resetM),
    .rd_en   (rd_en),
    .rd_dir  (rd_dir),
    .rd_dato (codigo),
    .we      (we),
    .wr_dir  (wr_dir),
    .wr_dato (wr_dato)
  );

  assign en_rango = (bus.wr_col < COLS_L) && (bus.wr_fila < ROWS_L);

  always_comb begin
    we      = 1'b0;
    wr_dir  = indice(bus.wr_fila, bus.wr_col);
    wr_dato = bus.wr_codigo;
    if (estado == BORRANDO) begin
      we      = !bus.video_on;
      wr_dir  = cnt;
      wr_dato = COD_BLANCO;
    end else if (estado == ESCRIBE) begin
      we = en_rango;
    end
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      estado  <= INACTIVO;
      cnt     <= '0;
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      case (estado)
        INACTIVO: begin
          if (bus.borrar) begin
            estado  <= BORRANDO;
            ocupado <= 1'b1;
            cnt     <= '0;
          end else if (bus.wr_req && !bus.video_on) begin
            estado <= ESCRIBE;
          end
        end
        // Granted in blanking, so the write completes even if video_on rises now.
        ESCRIBE: begin
          wr_ack <= 1'b1;
          wr_err <= !en_rango;
          estado <= ESPERA;
        end
        ESPERA: begin
          if (!bus.wr_req) estado <= INACTIVO;
        end
        BORRANDO: begin
          if (!bus.video_on) begin
            if (cnt == ULTIMA) begin
              cnt     <= '0;
              ocupado <= 1'b0;
              estado  <= INACTIVO;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: estado <= INACTIVO;
      endcase
    end
  end

  assign bus.rom_dir    = {codigo, qv_c1};
  assign bus.selec_px   = selec_px;
  assign bus.pix_valido = pix_valido;
  assign bus.wr_ack     = wr_ack;
  assign bus.wr_err     = wr_err;
  assign bus.ocupado    = ocupado;
  assign bus.estado     = estado;

endmodule
